// File: rtl/cntry_car_sensor_pkg.sv
// Definitions shared between the country-road car sensor and the signal controller:
// light codes, sensor state encodings and a light-decoding helper.
package cntry_car_sensor_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'd0,
        LIGHT_YELLOW = 2'd1,
        LIGHT_GREEN  = 2'd2,
        LIGHT_RSVD   = 2'd3
    } light_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVE   = 2'd2,
        ST_HOLDOFF = 2'd3
    } sensor_state_t;

    // The unused code 3 is read as red so a corrupted light code never holds a release open.
    function automatic logic is_red(input logic [1:0] code);
        return (code == LIGHT_RED) || (code == LIGHT_RSVD);
    endfunction

endpackage

// File: rtl/cntry_car_sensor_loop_debounce.sv
// Inductive-loop conditioner: 2-flop synchronizer, stability debouncer and a registered
// one-cycle pulse on each accepted rising level (vehicle arrives over the loop).
module loop_debounce
    import cntry_car_sensor_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic clock,
    input  logic clear,
    input  logic raw,
    output logic rise_p
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    // The level flips on the first disagreeing sample after DEBOUNCE disagreeing ones in a row.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_FULL) begin
                db_d    = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign rise_p = pulse_q;

endmodule

// File: rtl/cntry_car_sensor.sv
// Country-road vehicle detector: counts queued cars from two loops and raises request x,
// forcing a release after MAX_GREEN cycles of continuous country green.
module cntry_car_sensor
    import cntry_car_sensor_pkg::*;
#(
    parameter int DEBOUNCE  = 3,
    parameter int CNT_W     = 4,
    parameter int MAX_GREEN = 20
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             arr_raw,
    input  logic             dep_raw,
    input  logic [1:0]       cntry,
    output logic             x,
    output logic [CNT_W-1:0] queue,
    output logic             overflow,
    output logic             forced
);

    localparam int TMR_W = $clog2(MAX_GREEN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Q_MAX    = '1;

    logic arr_p;
    logic dep_p;

    loop_debounce #(.DEBOUNCE(DEBOUNCE)) u_arr_loop (
        .clock  (clock),
        .clear  (clear),
        .raw    (arr_raw),
        .rise_p (arr_p)
    );

    loop_debounce #(.DEBOUNCE(DEBOUNCE)) u_dep_loop (
        .clock  (clock),
        .clear  (clear),
        .raw    (dep_raw),
        .rise_p (dep_p)
    );

    logic [CNT_W-1:0] queue_q, queue_d;
    logic             overflow_q, overflow_d;
    sensor_state_t    state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             x_q, x_d;
    logic             forced_q, forced_d;

    // A simultaneous arrival and departure cancel out, so neither saturates nor underflows.
    always_comb begin
        queue_d    = queue_q;
        overflow_d = overflow_q;
        if (arr_p && !dep_p) begin
            if (queue_q == Q_MAX) begin
                overflow_d = 1'b1;
            end else begin
                queue_d = queue_q + CNT_W'(1);
            end
        end else if (dep_p && !arr_p && (queue_q != '0)) begin
            queue_d = queue_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            ST_IDLE: begin
                if (queue_q != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cntry == LIGHT_GREEN) begin
                    state_d = ST_SERVE;
                    timer_d = '0;
                end
            end
            ST_SERVE: begin
                if (queue_q == '0) begin
                    state_d = ST_IDLE;
                end else if (cntry != LIGHT_GREEN) begin
                    state_d = ST_REQ;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_HOLDOFF;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_HOLDOFF: begin
                // Wait for the controller to actually reach red before asking again.
                if (is_red(cntry)) begin
                    state_d = (queue_q != '0) ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        x_d      = (state_d == ST_REQ) || (state_d == ST_SERVE);
        forced_d = (state_d == ST_HOLDOFF);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            queue_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            x_q        <= 1'b0;
            forced_q   <= 1'b0;
        end else begin
            queue_q    <= queue_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            x_q        <= x_d;
            forced_q   <= forced_d;
        end
    end

    assign x        = x_q;
    assign queue    = queue_q;
    assign overflow = overflow_q;
    assign forced   = forced_q;

endmodule

// File: tb/tb_cntry_car_sensor.sv
// Bench for cntry_car_sensor: directed scenarios with fixed expectations plus a random soak
// compared cycle by cycle against a sliding-window behavioural model.
module tb_cntry_car_sensor;

    localparam int DEB  = 3;
    localparam int CW   = 2;
    localparam int MG   = 20;
    localparam int QMAX = (1 << CW) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_REQ   = 1;
    localparam int M_SERVE = 2;
    localparam int M_HOLD  = 3;

    logic          clock = 1'b0;
    logic          clear;
    logic          arr_raw;
    logic          dep_raw;
    logic [1:0]    cntry;
    logic          x;
    logic [CW-1:0] queue;
    logic          overflow;
    logic          forced;

    int n_checks = 0;
    int n_fail   = 0;

    cntry_car_sensor #(
        .DEBOUNCE  (DEB),
        .CNT_W     (CW),
        .MAX_GREEN (MG)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .arr_raw  (arr_raw),
        .dep_raw  (dep_raw),
        .cntry    (cntry),
        .x        (x),
        .queue    (queue),
        .overflow (overflow),
        .forced   (forced)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic         m_s1a = 0, m_s2a = 0, m_s1d = 0, m_s2d = 0;
    logic [DEB:0] m_ha = '0, m_hd = '0;
    logic         m_dba = 0, m_dbd = 0, m_pa = 0, m_pd = 0;
    int           m_q = 0;
    logic         m_ovf = 0;
    int           m_mode = M_IDLE;
    int           m_served = 0;
    logic         m_x = 0, m_forced = 0;

    // A level is accepted once the last DEB+1 synchronized samples all disagree with it.
    task automatic deb_model(inout logic [DEB:0] h, input logic s, inout logic db, output logic p);
        h = {h[DEB-1:0], s};
        p = 1'b0;
        if (h == {(DEB+1){~db}}) begin
            db = ~db;
            p  = db;
        end
    endtask

    task automatic model_edge();
        int nq;
        logic pa, pd;
        if (clear) begin
            m_s1a = 0; m_s2a = 0; m_s1d = 0; m_s2d = 0;
            m_ha = '0; m_hd = '0; m_dba = 0; m_dbd = 0; m_pa = 0; m_pd = 0;
            m_q = 0; m_ovf = 0; m_mode = M_IDLE; m_served = 0;
        end else begin
            nq = m_q;
            if (m_pa && !m_pd) begin
                if (m_q == QMAX) m_ovf = 1'b1;
                else nq = m_q + 1;
            end else if (m_pd && !m_pa && m_q > 0) begin
                nq = m_q - 1;
            end
            if (m_mode == M_IDLE) begin
                if (m_q != 0) m_mode = M_REQ;
            end else if (m_mode == M_REQ) begin
                if (cntry == 2) begin
                    m_mode = M_SERVE;
                    m_served = 0;
                end
            end else if (m_mode == M_SERVE) begin
                m_served++;
                if (m_q == 0) m_mode = M_IDLE;
                else if (cntry != 2) m_mode = M_REQ;
                else if (m_served == MG) m_mode = M_HOLD;
            end else begin
                if (cntry == 0 || cntry == 3) m_mode = (m_q != 0) ? M_REQ : M_IDLE;
            end
            m_q = nq;
            deb_model(m_ha, m_s2a, m_dba, pa);
            deb_model(m_hd, m_s2d, m_dbd, pd);
            m_pa = pa;
            m_pd = pd;
            m_s2a = m_s1a; m_s1a = arr_raw;
            m_s2d = m_s1d; m_s1d = dep_raw;
        end
        m_x      = (m_mode == M_REQ) || (m_mode == M_SERVE);
        m_forced = (m_mode == M_HOLD);
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; arr_raw = 1'b0; dep_raw = 1'b0;
        step(); step();
        clear = 1'b0;
    endtask

    task automatic loop_pulse(input logic arr, input logic dep, input int hi, input int lo);
        arr_raw = arr; dep_raw = dep;
        repeat (hi) step();
        arr_raw = 1'b0; dep_raw = 1'b0;
        repeat (lo) step();
    endtask

    task automatic test_reset();
        clear = 1'b1; arr_raw = 1'b1; dep_raw = 1'b1; cntry = 2'd2;
        repeat (3) step();
        n_checks++; if (queue !== '0)    begin n_fail++; $display("FAIL reset_queue got=%0d exp=0", queue); end
        n_checks++; if (x !== 1'b0)      begin n_fail++; $display("FAIL reset_x got=%b exp=0", x); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_checks++; if (forced !== 1'b0) begin n_fail++; $display("FAIL reset_forced got=%b exp=0", forced); end
        // Arrival loop held high through reset: edge 0 is the first edge after release.
        clear = 1'b0; dep_raw = 1'b0; cntry = 2'd0;
        for (int e = 0; e <= 7; e++) begin
            step();
            n_checks++;
            if (queue !== CW'((e >= 6) ? 1 : 0)) begin
                n_fail++; $display("FAIL latency_queue edge=%0d got=%0d exp=%0d", e, queue, (e >= 6) ? 1 : 0);
            end
            n_checks++;
            if (x !== ((e >= 7) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL latency_x edge=%0d got=%b exp=%b", e, x, (e >= 7));
            end
        end
        arr_raw = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_glitch();
        do_clear();
        cntry = 2'd0;
        loop_pulse(1'b1, 1'b0, 2, 10);
        n_checks++; if (queue !== '0) begin n_fail++; $display("FAIL glitch_queue got=%0d exp=0", queue); end
        n_checks++; if (x !== 1'b0)   begin n_fail++; $display("FAIL glitch_x got=%b exp=0", x); end
        begin
            logic [9:0] pat;
            pat = 10'b11_0_11_0_1111;
            for (int i = 0; i < 10; i++) begin
                arr_raw = pat[i];
                step();
            end
        end
        arr_raw = 1'b0;
        repeat (10) step();
        n_checks++; if (queue !== CW'(1)) begin n_fail++; $display("FAIL glitchy_pulse_queue got=%0d exp=1", queue); end
    endtask

    task automatic test_simultaneous();
        do_clear();
        cntry = 2'd0;
        loop_pulse(1'b0, 1'b1, 6, 6);
        n_checks++; if (queue !== '0) begin n_fail++; $display("FAIL underflow_queue got=%0d exp=0", queue); end
        loop_pulse(1'b1, 1'b0, 6, 6);
        loop_pulse(1'b1, 1'b0, 6, 6);
        n_checks++; if (queue !== CW'(2)) begin n_fail++; $display("FAIL two_arrivals_queue got=%0d exp=2", queue); end
        loop_pulse(1'b1, 1'b1, 6, 6);
        n_checks++; if (queue !== CW'(2)) begin n_fail++; $display("FAIL simultaneous_queue got=%0d exp=2", queue); end
        n_checks++; if (x !== 1'b1)       begin n_fail++; $display("FAIL simultaneous_x got=%b exp=1", x); end
    endtask

    task automatic test_saturation();
        do_clear();
        cntry = 2'd0;
        repeat (3) loop_pulse(1'b1, 1'b0, 6, 6);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pre_sat_overflow got=%b exp=0", overflow); end
        loop_pulse(1'b1, 1'b0, 6, 6);
        n_checks++; if (queue !== CW'(3))  begin n_fail++; $display("FAIL sat_queue got=%0d exp=3", queue); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_overflow got=%b exp=1", overflow); end
        loop_pulse(1'b0, 1'b1, 6, 6);
        n_checks++; if (queue !== CW'(2))  begin n_fail++; $display("FAIL post_sat_queue got=%0d exp=2", queue); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sticky_overflow got=%b exp=1", overflow); end
    endtask

    task automatic test_forced_release();
        do_clear();
        cntry = 2'd0;
        repeat (2) loop_pulse(1'b1, 1'b0, 6, 6);
        cntry = 2'd2;
        step();
        repeat (MG - 1) step();
        n_checks++; if (x !== 1'b1)      begin n_fail++; $display("FAIL serve_x_before_limit got=%b exp=1", x); end
        step();
        n_checks++; if (x !== 1'b0)      begin n_fail++; $display("FAIL forced_x got=%b exp=0", x); end
        n_checks++; if (forced !== 1'b1) begin n_fail++; $display("FAIL forced_flag got=%b exp=1", forced); end
        repeat (3) step();
        n_checks++; if (x !== 1'b0)      begin n_fail++; $display("FAIL holdoff_green_x got=%b exp=0", x); end
        cntry = 2'd0;
        step();
        n_checks++; if (x !== 1'b1)      begin n_fail++; $display("FAIL release_x got=%b exp=1", x); end
        n_checks++; if (forced !== 1'b0) begin n_fail++; $display("FAIL release_forced got=%b exp=0", forced); end
    endtask

    task automatic test_reset_mid_serve();
        do_clear();
        cntry = 2'd0;
        repeat (3) loop_pulse(1'b1, 1'b0, 6, 6);
        cntry = 2'd2;
        repeat (3) step();
        n_checks++; if (x !== 1'b1) begin n_fail++; $display("FAIL serve_x got=%b exp=1", x); end
        clear = 1'b1;
        step();
        n_checks++; if (queue !== '0)    begin n_fail++; $display("FAIL mid_reset_queue got=%0d exp=0", queue); end
        n_checks++; if (x !== 1'b0)      begin n_fail++; $display("FAIL mid_reset_x got=%b exp=0", x); end
        n_checks++; if (forced !== 1'b0) begin n_fail++; $display("FAIL mid_reset_forced got=%b exp=0", forced); end
        clear = 1'b0;
        repeat (5) step();
        n_checks++; if (x !== 1'b0)      begin n_fail++; $display("FAIL idle_after_reset_x got=%b exp=0", x); end
    endtask

    task automatic test_random();
        do_clear();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) arr_raw = ~arr_raw;
            if ($urandom_range(0, 6) == 0) dep_raw = ~dep_raw;
            if ($urandom_range(0, 29) == 0) cntry = 2'($urandom_range(0, 3));
            clear = ($urandom_range(0, 799) == 0);
            step();
            n_checks++;
            if (queue !== CW'(m_q)) begin n_fail++; $display("FAIL rand_queue cyc=%0d got=%0d exp=%0d", i, queue, m_q); end
            n_checks++;
            if (x !== m_x) begin n_fail++; $display("FAIL rand_x cyc=%0d got=%b exp=%b", i, x, m_x); end
            n_checks++;
            if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_overflow cyc=%0d got=%b exp=%b", i, overflow, m_ovf); end
            n_checks++;
            if (forced !== m_forced) begin n_fail++; $display("FAIL rand_forced cyc=%0d got=%b exp=%b", i, forced, m_forced); end
        end
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1; arr_raw = 1'b0; dep_raw = 1'b0; cntry = 2'd0;
        test_reset();
        test_glitch();
        test_simultaneous();
        test_saturation();
        test_forced_release();
        test_reset_mid_serve();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
